// File: rtl/zx_video_pkg.sv
// Shared definitions for the ZX Spectrum screen-memory write path.
// Holds the screen geometry, the fill engine state encoding and the layout
// of one buffered CPU write ({13-bit screen offset, 8-bit data}).
package zx_video_pkg;

    localparam int          SCREEN_BYTES = 6912;
    localparam int          PIX_BYTES    = 6144;
    localparam logic [12:0] ATTR_BASE    = 13'd6144;
    localparam logic [12:0] PIX_LAST     = 13'd6143;
    localparam logic [12:0] SCREEN_LAST  = 13'd6911;
    localparam int          ENTRY_W      = 21;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DRAIN,
        FILL_PIX,
        FILL_ATTR,
        DONE
    } fill_state_t;

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [12:0] addr,
                                                      input logic [7:0]  data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/zx_wr_fifo.sv
// Synchronous FIFO buffering CPU screen writes.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   push, wdata      write request and entry; ignored when full unless popping
//   pop              remove the head entry; ignored when empty
//   head_next        entry that will be at the head after this clock edge,
//                    so the consumer can register it without a bubble
//   count_next       occupancy after this clock edge
//   full, empty      current occupancy flags
module zx_wr_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 21,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head_next,
    output logic [CW-1:0]    count_next,
    output logic             full,
    output logic             empty
);

    localparam int AW = CW - 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    count_rem;
    logic             push_eff;
    logic             pop_eff;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        // A pop frees the slot a simultaneous push needs, so full+push+pop is legal.
        pop_eff    = pop && !empty;
        push_eff   = push && (!full || pop_eff);
        wr_ptr_d   = wr_ptr_q + AW'(push_eff);
        rd_ptr_d   = rd_ptr_q + AW'(pop_eff);
        count_rem  = count_q - CW'(pop_eff);
        count_d    = count_rem + CW'(push_eff);
        count_next = count_d;
        // When nothing survives the pop, the new head is the entry being written
        // this cycle; that slot is not in memory yet, so forward it.
        head_next  = (count_rem == '0) ? wdata : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/zx_vram_writer.sv
// Write side of the ZX Spectrum screen memory.
// Captures CPU writes to the screen window, buffers them, and drains them to
// the video RAM write port. A fill engine (CLS) can write the whole screen:
// pixel bytes 0..6143 then attribute bytes 6144..6911.
// The reset input is expected to be already synchronised on deassertion.
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   cpu_wr/cpu_addr/cpu_data         CPU write strobe, address, data
//   cpu_wait                         registered back-pressure (buffer almost full)
//   fill_start/fill_pixel/fill_attr  start pulse and fill bytes
//   fill_busy/fill_done              fill engine active / completion pulse
//   overflow/ovf_clr                 sticky dropped-write flag and its clear
//   vram_we/vram_addr/vram_din       registered write request to the VRAM arbiter
//   vram_ready                       arbiter accepts the request this cycle
module zx_vram_writer
    import zx_video_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] BASE_ADDR   = 16'h4000,
    parameter int          ALMOST_FULL = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    output logic        cpu_wait,
    input  logic        fill_start,
    input  logic [7:0]  fill_pixel,
    input  logic [7:0]  fill_attr,
    output logic        fill_busy,
    output logic        fill_done,
    output logic        overflow,
    input  logic        ovf_clr,
    output logic        vram_we,
    output logic [12:0] vram_addr,
    output logic [7:0]  vram_din,
    input  logic        vram_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fill_state_t          state_q, state_d;
    logic [7:0]           fill_pix_q, fill_pix_d;
    logic [7:0]           fill_attr_q, fill_attr_d;
    logic                 vram_we_q, vram_we_d;
    logic [12:0]          vram_addr_q, vram_addr_d;
    logic [7:0]           vram_din_q, vram_din_d;
    logic                 cpu_wait_q, cpu_wait_d;
    logic                 overflow_q, overflow_d;

    logic [15:0]          cpu_offset;
    logic                 push_req;
    logic                 pop;
    logic                 xfer;
    logic                 fifo_src;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        count_next;
    logic [ENTRY_W-1:0]   head_next;

    // Unsigned 16-bit difference: addresses below BASE_ADDR wrap to large values.
    assign cpu_offset = cpu_addr - BASE_ADDR;
    assign push_req   = cpu_wr && (cpu_offset < 16'(SCREEN_BYTES));

    zx_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push_req),
        .wdata      (pack_entry(cpu_offset[12:0], cpu_data)),
        .pop        (pop),
        .head_next  (head_next),
        .count_next (count_next),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        fill_pix_d  = fill_pix_q;
        fill_attr_d = fill_attr_q;
        vram_we_d   = vram_we_q;
        vram_addr_d = vram_addr_q;
        vram_din_d  = vram_din_q;

        xfer     = vram_we_q && vram_ready;
        // In IDLE/WAIT_DRAIN the output registers mirror the FIFO head,
        // so a completed transfer retires that head.
        fifo_src = (state_q == IDLE) || (state_q == WAIT_DRAIN);
        pop      = fifo_src && xfer;

        case (state_q)
            IDLE: begin
                if (fill_start) begin
                    fill_pix_d  = fill_pixel;
                    fill_attr_d = fill_attr;
                    state_d     = fifo_empty ? FILL_PIX : WAIT_DRAIN;
                end
            end
            WAIT_DRAIN: begin
                // Leave once the last buffered entry transfers on this edge.
                if (count_next == '0) begin
                    state_d = FILL_PIX;
                end
            end
            FILL_PIX: begin
                if (xfer && (vram_addr_q == PIX_LAST)) begin
                    state_d = FILL_ATTR;
                end
            end
            FILL_ATTR: begin
                if (xfer && (vram_addr_q == SCREEN_LAST)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Output registers are loaded according to where the FSM is heading.
        case (state_d)
            IDLE, WAIT_DRAIN: begin
                vram_we_d = (count_next != '0);
                if (count_next != '0) begin
                    vram_addr_d = head_next[ENTRY_W-1:8];
                    vram_din_d  = head_next[7:0];
                end
            end
            FILL_PIX: begin
                vram_we_d  = 1'b1;
                vram_din_d = fill_pix_d;
                if (state_q != FILL_PIX) begin
                    vram_addr_d = '0;
                end else if (xfer) begin
                    vram_addr_d = vram_addr_q + 13'd1;
                end
            end
            FILL_ATTR: begin
                vram_we_d  = 1'b1;
                vram_din_d = fill_attr_q;
                if (state_q == FILL_PIX) begin
                    vram_addr_d = ATTR_BASE;
                end else if (xfer) begin
                    vram_addr_d = vram_addr_q + 13'd1;
                end
            end
            default: begin
                vram_we_d = 1'b0;
            end
        endcase

        cpu_wait_d = (FIFO_DEPTH - int'(count_next)) <= ALMOST_FULL;

        // A dropped write takes priority over a clear in the same cycle.
        if (push_req && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            fill_pix_q  <= '0;
            fill_attr_q <= '0;
            vram_we_q   <= 1'b0;
            vram_addr_q <= '0;
            vram_din_q  <= '0;
            cpu_wait_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_pix_q  <= fill_pix_d;
            fill_attr_q <= fill_attr_d;
            vram_we_q   <= vram_we_d;
            vram_addr_q <= vram_addr_d;
            vram_din_q  <= vram_din_d;
            cpu_wait_q  <= cpu_wait_d;
            overflow_q  <= overflow_d;
        end
    end

    assign vram_we   = vram_we_q;
    assign vram_addr = vram_addr_q;
    assign vram_din  = vram_din_q;
    assign cpu_wait  = cpu_wait_q;
    assign overflow  = overflow_q;
    assign fill_busy = (state_q == WAIT_DRAIN) || (state_q == FILL_PIX) ||
                       (state_q == FILL_ATTR);
    assign fill_done = (state_q == DONE);

endmodule

// File: tb/tb_zx_vram_writer.sv
module tb_zx_vram_writer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_wr;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_wait;
    logic        fill_start;
    logic [7:0]  fill_pixel;
    logic [7:0]  fill_attr;
    logic        fill_busy;
    logic        fill_done;
    logic        overflow;
    logic        ovf_clr;
    logic        vram_we;
    logic [12:0] vram_addr;
    logic [7:0]  vram_din;
    logic        vram_ready;

    always #5 clk = ~clk;

    zx_vram_writer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .cpu_wait   (cpu_wait),
        .fill_start (fill_start),
        .fill_pixel (fill_pixel),
        .fill_attr  (fill_attr),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_din   (vram_din),
        .vram_ready (vram_ready)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [20:0] wlog[$];
    logic [20:0] exp_q[$];
    int          stall_viol = 0;
    int          done_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [12:0] prev_addr = '0;
    logic [7:0]  prev_din = '0;

    // Transfer log and stall-stability watch, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!vram_we || vram_addr != prev_addr || vram_din != prev_din))
                stall_viol <= stall_viol + 1;
            if (vram_we && vram_ready)
                wlog.push_back({vram_addr, vram_din});
            if (fill_done)
                done_cnt <= done_cnt + 1;
            prev_stall <= vram_we && !vram_ready;
            prev_addr  <= vram_addr;
            prev_din   <= vram_din;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cpu_wr   = 1'b1;
        cpu_addr = a;
        cpu_data = d;
        step();
        cpu_wr   = 1'b0;
    endtask

    function automatic logic [20:0] ent(input int a, input int d);
        return {13'(a), 8'(d)};
    endfunction

    initial begin
        int          n;
        int          bad;
        int          d0;
        logic [15:0] a;
        logic [15:0] off;
        logic [7:0]  d;

        cpu_wr = 0; cpu_addr = 0; cpu_data = 0; fill_start = 0;
        fill_pixel = 0; fill_attr = 0; ovf_clr = 0; vram_ready = 1'b1;
        reset_n = 1'b0;
        repeat (3) step();
        chk("rst_we", vram_we, 0);
        chk("rst_addr", vram_addr, 0);
        chk("rst_din", vram_din, 0);
        chk("rst_wait", cpu_wait, 0);
        chk("rst_busy", fill_busy, 0);
        chk("rst_done", fill_done, 0);
        chk("rst_ovf", overflow, 0);
        reset_n = 1'b1;
        step();
        chk("idle_we", vram_we, 0);

        // Single write
        wlog.delete();
        wr(16'h4000, 8'hAA);
        chk("single_we", vram_we, 1);
        chk("single_addr", vram_addr, 0);
        chk("single_din", vram_din, 8'hAA);
        step();
        chk("single_we_off", vram_we, 0);
        step();
        chk("single_cnt", wlog.size(), 1);

        // Range check
        wlog.delete();
        wr(16'h3FFF, 8'h11);
        wr(16'h5B00, 8'h22);
        wr(16'h5AFF, 8'h47);
        wr(16'h5800, 8'h38);
        repeat (4) step();
        chk("range_cnt", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("range_last", wlog[0], ent(6911, 8'h47));
            chk("range_attr", wlog[1], ent(6144, 8'h38));
        end
        chk("range_ovf", overflow, 0);

        // Back-pressure and overflow
        vram_ready = 1'b0;
        wlog.delete();
        for (int i = 0; i < 9; i++) begin
            wr(16'h4000 + 16'(i), 8'h10 + 8'(i));
            chk($sformatf("bp_wait%0d", i), cpu_wait, (i >= 6) ? 1 : 0);
        end
        chk("bp_ovf", overflow, 1);
        chk("bp_hold_addr", vram_addr, 0);
        chk("bp_hold_din", vram_din, 8'h10);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("bp_ovf_clr", overflow, 0);
        vram_ready = 1'b1;
        repeat (10) step();
        chk("bp_cnt", wlog.size(), 8);
        bad = 0;
        for (int i = 0; i < wlog.size(); i++)
            if (wlog[i] !== ent(i, 8'h10 + i)) bad++;
        chk("bp_order_bad", bad, 0);
        chk("bp_wait_end", cpu_wait, 0);

        // Full-screen fill
        wlog.delete();
        fill_pixel = 8'h00; fill_attr = 8'h38;
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        fill_pixel = 8'hFF;
        chk("fill_busy", fill_busy, 1);
        n = 1;
        while (!fill_done && n < 8000) begin
            fill_start = (n == 100);
            step();
            n++;
        end
        fill_start = 1'b0;
        chk("fill_done_lat", n, 6913);
        step();
        chk("fill_done_pulse", fill_done, 0);
        chk("fill_busy_end", fill_busy, 0);
        chk("fill_cnt", wlog.size(), 6912);
        bad = 0;
        for (int i = 0; i < wlog.size(); i++)
            if (wlog[i] !== ent(i, (i < 6144) ? 8'h00 : 8'h38)) bad++;
        chk("fill_stream_bad", bad, 0);

        // Fill with buffered entries and a write during FILL_PIX
        vram_ready = 1'b0;
        wlog.delete();
        wr(16'h4010, 8'h01);
        wr(16'h5801, 8'h02);
        wr(16'h4100, 8'h03);
        fill_pixel = 8'h55; fill_attr = 8'h07;
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        chk("wd_busy", fill_busy, 1);
        chk("wd_head", vram_addr, 13'h010);
        vram_ready = 1'b1;
        n = 1;
        while (!fill_done && n < 8000) begin
            cpu_wr = (n == 20); cpu_addr = 16'h4000; cpu_data = 8'hEE;
            step();
            n++;
        end
        cpu_wr = 1'b0;
        repeat (5) step();
        chk("wd_cnt", wlog.size(), 6916);
        if (wlog.size() == 6916) begin
            chk("wd_e0", wlog[0], ent(16'h010, 8'h01));
            chk("wd_e1", wlog[1], ent(16'h1801, 8'h02));
            chk("wd_e2", wlog[2], ent(16'h100, 8'h03));
            chk("wd_fill0", wlog[3], ent(0, 8'h55));
            chk("wd_attr0", wlog[3 + 6144], ent(6144, 8'h07));
            chk("wd_last", wlog[3 + 6911], ent(6911, 8'h07));
            chk("wd_cpu_after", wlog[3 + 6912], ent(0, 8'hEE));
        end

        // Random ready: CPU traffic then a fill
        wlog.delete();
        exp_q.delete();
        for (int c = 0; c < 60; c++) begin
            vram_ready = 1'($urandom_range(0, 1));
            if (!cpu_wait && $urandom_range(0, 1) == 1) begin
                a   = 16'h3F00 + 16'($urandom_range(0, 16'h1C00));
                d   = 8'($urandom);
                off = a - 16'h4000;
                cpu_wr = 1'b1; cpu_addr = a; cpu_data = d;
                if (off < 16'd6912) exp_q.push_back({off[12:0], d});
            end else begin
                cpu_wr = 1'b0;
            end
            step();
        end
        cpu_wr = 1'b0;
        for (int c = 0; c < 60; c++) begin
            vram_ready = 1'($urandom_range(0, 1));
            step();
        end
        fill_pixel = 8'h5A; fill_attr = 8'hA5;
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        for (int i = 0; i < 6912; i++) exp_q.push_back(ent(i, (i < 6144) ? 8'h5A : 8'hA5));
        n = 0;
        while (!fill_done && n < 30000) begin
            vram_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        chk("rnd_fill_timeout", (n < 30000) ? 1 : 0, 1);
        vram_ready = 1'b1;
        repeat (5) step();
        chk("rnd_cnt", wlog.size(), exp_q.size());
        bad = 0;
        for (int i = 0; i < wlog.size() && i < exp_q.size(); i++)
            if (wlog[i] !== exp_q[i]) bad++;
        chk("rnd_stream_bad", bad, 0);
        chk("rnd_stall_viol", stall_viol, 0);
        chk("rnd_ovf", overflow, 0);

        // Reset during FILL_ATTR
        fill_pixel = 8'h11; fill_attr = 8'h22;
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        n = 0;
        while (!(fill_busy && vram_addr >= 13'd6200) && n < 8000) begin
            step();
            n++;
        end
        chk("mr_reach_attr", (vram_addr >= 13'd6200) ? 1 : 0, 1);
        d0 = done_cnt;
        reset_n = 1'b0;
        #1;
        chk("mr_we", vram_we, 0);
        chk("mr_addr", vram_addr, 0);
        chk("mr_din", vram_din, 0);
        chk("mr_busy", fill_busy, 0);
        chk("mr_wait", cpu_wait, 0);
        repeat (3) step();
        reset_n = 1'b1;
        repeat (800) step();
        chk("mr_no_done", done_cnt, d0);
        chk("mr_idle_we", vram_we, 0);
        fill_pixel = 8'h99; fill_attr = 8'h44;
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        chk("mr_restart_we", vram_we, 1);
        chk("mr_restart_addr", vram_addr, 0);
        chk("mr_restart_din", vram_din, 8'h99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
